// File: rtl/pipe_ctrl_skid_stage_pkg.sv
// Shared definitions for the decode->execute control stage: state encoding,
// control-word field offsets and a state-to-occupancy helper.
package pipe_ctrl_skid_stage_pkg;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    localparam int unsigned DEF_W  = 26;
    localparam int unsigned DEF_CW = 16;

    // Control word layout: {op[6:0], f3[2:0], f7, rd[4:0], rs1[4:0], rs2[4:0]}
    localparam int unsigned RS2_LSB = 0;
    localparam int unsigned RS1_LSB = 5;
    localparam int unsigned RD_LSB  = 10;
    localparam int unsigned F7_LSB  = 15;
    localparam int unsigned F3_LSB  = 16;
    localparam int unsigned OP_LSB  = 19;

    function automatic logic [1:0] occ_of(input state_t s);
        case (s)
            S_ONE:   return 2'd1;
            S_TWO:   return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_ctrl_skid_stage_sat_counter.sv
// Saturating event counter: adds 0..3 per cycle when inc is set, sticks at
// all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic [1:0]    amount,
    output logic [CW-1:0] cnt
);

    logic [CW:0] sum;

    always_comb begin
        sum = {1'b0, cnt} + {{(CW-1){1'b0}}, amount};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (amount != 2'd0)) begin
            cnt <= sum[CW] ? '1 : sum[CW-1:0];
        end
    end

endmodule

// File: rtl/pipe_ctrl_skid_stage.sv
// Decode->execute control pipeline register with a 2-entry skid buffer,
// stall/flush handling and saturating bubble/kill performance counters.
module pipe_ctrl_skid_stage
    import pipe_ctrl_skid_stage_pkg::*;
#(
    parameter int unsigned  W       = 26,
    parameter logic [W-1:0] NOP_VAL = '0,
    parameter int unsigned  CW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [1:0]    occupancy,
    output logic [CW-1:0] bubble_cnt,
    output logic [CW-1:0] kill_cnt
);

    state_t       state, state_nxt;
    logic [W-1:0] main_q, main_nxt;
    logic [W-1:0] skid_q, skid_nxt;
    logic         skid_valid;
    logic         acc;
    logic         emit;
    logic [1:0]   kill_amt;

    // in_ready depends only on registered state and stall/flush, so a
    // downstream out_ready never reaches the decode stage combinationally.
    always_comb begin
        skid_valid = (state == S_TWO);
        in_ready   = ~skid_valid & ~stall & ~flush;
        out_valid  = (state != S_EMPTY);
        out_data   = main_q;
        occupancy  = occ_of(state);
        acc        = in_valid & in_ready;
        emit       = out_valid & out_ready;
        kill_amt   = occupancy - {1'b0, emit};
    end

    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        if (flush) begin
            state_nxt = S_EMPTY;
            main_nxt  = NOP_VAL;
            skid_nxt  = NOP_VAL;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (acc) begin
                        state_nxt = S_ONE;
                        main_nxt  = in_data;
                    end
                end
                S_ONE: begin
                    if (acc && emit) begin
                        main_nxt = in_data;
                    end else if (acc) begin
                        state_nxt = S_TWO;
                        skid_nxt  = in_data;
                    end else if (emit) begin
                        state_nxt = S_EMPTY;
                        main_nxt  = NOP_VAL;
                    end
                end
                S_TWO: begin
                    if (emit) begin
                        state_nxt = S_ONE;
                        main_nxt  = skid_q;
                        skid_nxt  = NOP_VAL;
                    end
                end
                default: begin
                    state_nxt = S_EMPTY;
                    main_nxt  = NOP_VAL;
                    skid_nxt  = NOP_VAL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_EMPTY;
            main_q <= NOP_VAL;
            skid_q <= NOP_VAL;
        end else begin
            state  <= state_nxt;
            main_q <= main_nxt;
            skid_q <= skid_nxt;
        end
    end

    sat_counter #(.CW(CW)) u_bubble_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (out_ready & ~out_valid),
        .amount (2'd1),
        .cnt    (bubble_cnt)
    );

    sat_counter #(.CW(CW)) u_kill_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (flush),
        .amount (kill_amt),
        .cnt    (kill_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl_skid_stage.sv
// Scoreboard bench for pipe_ctrl_skid_stage: directed handshake scenarios on a
// CW=16 instance plus bubble-counter saturation on a CW=2 instance.
module tb_pipe_ctrl_skid_stage;
    import pipe_ctrl_skid_stage_pkg::*;

    localparam int unsigned  W   = 26;
    localparam int unsigned  CW  = 16;
    localparam logic [W-1:0] NOP = 26'h0000013;

    logic          clk;
    logic          rst;
    logic          stall, flush, in_valid, out_ready;
    logic [W-1:0]  in_data;
    logic          in_ready, out_valid;
    logic [W-1:0]  out_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] bubble_cnt, kill_cnt;

    logic          rst2, stall2, flush2, in_valid2, out_ready2;
    logic [W-1:0]  in_data2;
    logic          in_ready2, out_valid2;
    logic [W-1:0]  out_data2;
    logic [1:0]    occupancy2;
    logic [1:0]    bubble_cnt2, kill_cnt2;

    int unsigned   errors = 0;
    int unsigned   checks = 0;
    logic [W-1:0]  exp_q[$];
    int unsigned   bub_model = 0;
    bit            mon_en = 0;
    bit            done2 = 0;

    pipe_ctrl_skid_stage #(.W(W), .NOP_VAL(NOP), .CW(CW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .bubble_cnt(bubble_cnt), .kill_cnt(kill_cnt)
    );

    pipe_ctrl_skid_stage #(.W(W), .CW(2)) dut2 (
        .clk(clk), .rst(rst2), .stall(stall2), .flush(flush2),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .occupancy(occupancy2), .bubble_cnt(bubble_cnt2), .kill_cnt(kill_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] mk(input int unsigned op, input int unsigned rd,
                                        input int unsigned rs1, input int unsigned rs2);
        logic [W-1:0] w;
        logic [31:0]  o, d, a, b;
        o = op; d = rd; a = rs1; b = rs2;
        w = '0;
        w[OP_LSB +: 7]  = o[6:0];
        w[RD_LSB +: 5]  = d[4:0];
        w[RS1_LSB +: 5] = a[4:0];
        w[RS2_LSB +: 5] = b[4:0];
        return w;
    endfunction

    // Monitor: compares DUT outputs against the expected-word queue each cycle.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            logic         v;
            logic [W-1:0] e;
            v = (exp_q.size() != 0);
            check("occupancy", 32'(occupancy), 32'(exp_q.size()));
            check("out_valid", 32'(out_valid), 32'(v));
            check("bubble_cnt", 32'(bubble_cnt), bub_model);
            if (!v) begin
                check("bubble_data", 32'(out_data), 32'(NOP));
            end else begin
                e = exp_q[0];
                check("out_data", 32'(out_data), 32'(e));
                if (out_ready) void'(exp_q.pop_front());
            end
            if (out_ready && !v) bub_model++;
        end
    end

    task automatic step(input logic iv, input logic [W-1:0] d, input logic st,
                        input logic fl, input logic ordy, input logic exp_rdy,
                        input string tag);
        in_valid = iv; in_data = d; stall = st; flush = fl; out_ready = ordy;
        @(negedge clk); #1;
        check(tag, 32'(in_ready), 32'(exp_rdy));
        if (fl) exp_q.delete();
        if (iv && exp_rdy) exp_q.push_back(d);
        @(posedge clk); #1;
    endtask

    initial begin
        int unsigned b0;
        rst = 1'b1; stall = 0; flush = 0; in_valid = 0; out_ready = 0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_out_data", 32'(out_data), 32'(NOP));
        check("rst_bubble", 32'(bubble_cnt), 32'd0);
        check("rst_kill", 32'(kill_cnt), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0; bub_model = 0; mon_en = 1;
        @(posedge clk); #1;

        // Streaming at full rate
        for (int unsigned i = 0; i < 8; i++)
            step(1, mk(7'h33, i + 1, i + 2, i + 3), 0, 0, 1, 1, "t1_in_ready");
        step(0, '0, 0, 0, 1, 1, "t1_drain");

        // Back-pressure fills the skid, then drains in order
        step(1, mk(7'h03, 1, 1, 1), 0, 0, 0, 1, "t2_a");
        step(1, mk(7'h03, 2, 2, 2), 0, 0, 0, 1, "t2_b");
        step(1, mk(7'h03, 3, 3, 3), 0, 0, 0, 0, "t2_c_blocked");
        check("t2_occ_full", 32'(occupancy), 32'd2);
        step(1, mk(7'h03, 3, 3, 3), 0, 0, 1, 0, "t2_release");
        step(1, mk(7'h03, 3, 3, 3), 0, 0, 1, 1, "t2_c_accept");
        step(0, '0, 0, 0, 1, 1, "t2_drain");

        // Flush with two held entries and no emit
        step(1, mk(7'h23, 4, 4, 4), 0, 0, 0, 1, "t3_d");
        step(1, mk(7'h23, 5, 5, 5), 0, 0, 0, 1, "t3_e");
        step(0, '0, 0, 1, 0, 0, "t3_flush");
        check("t3_out_valid", 32'(out_valid), 32'd0);
        check("t3_out_data", 32'(out_data), 32'(NOP));
        check("t3_kill_cnt", 32'(kill_cnt), 32'd2);

        // Load-use stall while execute keeps consuming
        step(1, mk(7'h13, 6, 6, 6), 0, 0, 1, 1, "t4_f");
        b0 = bub_model;
        step(1, mk(7'h13, 7, 7, 7), 1, 0, 1, 0, "t4_stall1");
        check("t4_valid_drop", 32'(out_valid), 32'd0);
        step(1, mk(7'h13, 7, 7, 7), 1, 0, 1, 0, "t4_stall2");
        check("t4_bubble", 32'(bubble_cnt), b0 + 1);
        step(1, mk(7'h13, 7, 7, 7), 0, 0, 1, 1, "t4_g");

        // Flush coinciding with an emit at occupancy 1
        step(1, mk(7'h6f, 8, 8, 8), 0, 1, 1, 0, "t5_flush");
        check("t5_kill_cnt", 32'(kill_cnt), 32'd2);
        check("t5_occ", 32'(occupancy), 32'd0);
        step(0, '0, 0, 0, 1, 1, "t5_idle");

        // Asynchronous reset with two entries in flight
        step(1, mk(7'h37, 9, 9, 9), 0, 0, 0, 1, "t6_i");
        step(1, mk(7'h37, 10, 10, 10), 0, 0, 0, 1, "t6_j");
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_occ", 32'(occupancy), 32'd0);
        check("t6_rst_data", 32'(out_data), 32'(NOP));
        check("t6_rst_bubble", 32'(bubble_cnt), 32'd0);
        check("t6_rst_kill", 32'(kill_cnt), 32'd0);
        check("t6_rst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        bub_model = 0;
        in_valid = 0; out_ready = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        step(1, mk(7'h17, 11, 11, 11), 0, 0, 1, 1, "t6_recover");
        step(0, '0, 0, 0, 1, 1, "t6_drain");
        step(0, '0, 0, 0, 1, 1, "t6_idle");

        for (int i = 0; i < 200 && !done2; i++) @(posedge clk);
        check("cw2_done", 32'(done2), 32'd1);
        mon_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // CW=2 instance: idle with out_ready=1 so bubble_cnt saturates
    initial begin
        rst2 = 1'b1; stall2 = 0; flush2 = 0; in_valid2 = 0; out_ready2 = 0; in_data2 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst2 = 1'b0; out_ready2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("cw2_bubble_2", 32'(bubble_cnt2), 32'd2);
        repeat (3) @(posedge clk);
        #1;
        check("cw2_bubble_sat", 32'(bubble_cnt2), 32'd3);
        check("cw2_kill", 32'(kill_cnt2), 32'd0);
        check("cw2_out_valid", 32'(out_valid2), 32'd0);
        rst2 = 1'b1;
        #1;
        check("cw2_rst_bubble", 32'(bubble_cnt2), 32'd0);
        done2 = 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
